// File: rtl/cv32e40x_clic_arbiter_if.sv
// CLIC request/acknowledge bundle between the source arbiter and the core.
// master: drives clic_irq_* and samples the ack; slave: the core side.
interface cv32e40x_clic_arbiter_if #(
   parameter int CLIC_ID_WIDTH = 5
);
   logic                     clic_irq_o;
   logic [CLIC_ID_WIDTH-1:0] clic_irq_id_o;
   logic [7:0]               clic_irq_level_o;
   logic [1:0]               clic_irq_priv_o;
   logic                     clic_irq_shv_o;
   logic                     irq_ack_i;
   logic [CLIC_ID_WIDTH-1:0] irq_ack_id_i;

   modport master (
      output clic_irq_o,
      output clic_irq_id_o,
      output clic_irq_level_o,
      output clic_irq_priv_o,
      output clic_irq_shv_o,
      input  irq_ack_i,
      input  irq_ack_id_i
   );

   modport slave (
      input  clic_irq_o,
      input  clic_irq_id_o,
      input  clic_irq_level_o,
      input  clic_irq_priv_o,
      input  clic_irq_shv_o,
      output irq_ack_i,
      output irq_ack_id_i
   );
endinterface

// File: rtl/cv32e40x_clic_arbiter.sv
// CLIC source block: pends NUM_IRQ lines, picks the highest-level enabled
// source and presents it on a registered request bundle.
// Ports: clk, rst (async, active-high); irq_i, irq_ie_i, irq_level_i,
// irq_shv_i, irq_trig_i per-source inputs; clic (master) request/ack
// bundle; pending_o pending state.
// Macro CV32E40X_CLIC_ARB_EDGE_EN enables rising-edge sources and
// ack-driven clears; without it every source is level-sensitive.
module cv32e40x_clic_arbiter #(
   parameter int NUM_IRQ       = 32,
   parameter int CLIC_ID_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IRQ-1:0]      irq_i,
   input  logic [NUM_IRQ-1:0]      irq_ie_i,
   input  logic [8*NUM_IRQ-1:0]    irq_level_i,
   input  logic [NUM_IRQ-1:0]      irq_shv_i,
   input  logic [NUM_IRQ-1:0]      irq_trig_i,
   cv32e40x_clic_arbiter_if.master clic,
   output logic [NUM_IRQ-1:0]      pending_o
);

   if (NUM_IRQ < 2 || NUM_IRQ > 1024 ||
       (2**CLIC_ID_WIDTH) < NUM_IRQ) begin : g_param_err
      $error("cv32e40x_clic_arbiter: bad NUM_IRQ/CLIC_ID_WIDTH");
   end

   typedef enum logic [1:0] {IDLE, PRESENT, BLANK} state_e;

   state_e state_q, state_d;

   logic [NUM_IRQ-1:0]       pend_q, pend_d;
   logic                     arb_valid;
   logic [CLIC_ID_WIDTH-1:0] arb_id;
   logic [7:0]               arb_level;
   logic                     arb_shv;
   logic [7:0]               lvl;

   logic                     irq_q, irq_d;
   logic [CLIC_ID_WIDTH-1:0] id_q, id_d;
   logic [7:0]               level_q, level_d;
   logic                     shv_q, shv_d;

`ifdef CV32E40X_CLIC_ARB_EDGE_EN
   logic [NUM_IRQ-1:0] irq_prev_q;
   logic [NUM_IRQ-1:0] clr;

   // A fresh edge in the clearing cycle wins over the clear.
   always_comb begin
      clr    = '0;
      pend_d = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         clr[i] = clic.irq_ack_i && irq_trig_i[i] &&
                  (clic.irq_ack_id_i == CLIC_ID_WIDTH'(i));
         pend_d[i] = irq_trig_i[i] ?
            ((pend_q[i] & ~clr[i]) | (irq_i[i] & ~irq_prev_q[i])) :
            irq_i[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq_prev_q <= '0;
      else     irq_prev_q <= irq_i;
   end
`else
   logic unused_signals;

   assign pend_d         = irq_i;
   assign unused_signals = ^{irq_trig_i, clic.irq_ack_id_i};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_d;
   end

   // Ascending scan with >= lets the higher ID win a level tie.
   always_comb begin
      arb_valid = 1'b0;
      arb_id    = '0;
      arb_level = '0;
      arb_shv   = 1'b0;
      lvl       = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         lvl = irq_level_i[8*i +: 8];
         if (pend_q[i] && irq_ie_i[i] &&
             lvl != 8'd0 && lvl >= arb_level) begin
            arb_valid = 1'b1;
            arb_id    = CLIC_ID_WIDTH'(i);
            arb_level = lvl;
            arb_shv   = irq_shv_i[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      irq_d   = irq_q;
      id_d    = id_q;
      level_d = level_q;
      shv_d   = shv_q;
      unique case (state_q)
         IDLE, BLANK: begin
            irq_d   = arb_valid;
            state_d = arb_valid ? PRESENT : IDLE;
            if (arb_valid) begin
               id_d    = arb_id;
               level_d = arb_level;
               shv_d   = arb_shv;
            end
         end
         PRESENT: begin
            if (clic.irq_ack_i) begin
               irq_d   = 1'b0;
               state_d = BLANK;
            end else if (arb_valid) begin
               irq_d   = 1'b1;
               id_d    = arb_id;
               level_d = arb_level;
               shv_d   = arb_shv;
            end else begin
               irq_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            irq_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         irq_q   <= 1'b0;
         id_q    <= '0;
         level_q <= '0;
         shv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         irq_q   <= irq_d;
         id_q    <= id_d;
         level_q <= level_d;
         shv_q   <= shv_d;
      end
   end

   assign clic.clic_irq_o       = irq_q;
   assign clic.clic_irq_id_o    = id_q;
   assign clic.clic_irq_level_o = level_q;
   assign clic.clic_irq_shv_o   = shv_q;
   assign clic.clic_irq_priv_o  = 2'b11;
   assign pending_o             = pend_q;

`ifndef SYNTHESIS
   ack_in_idle: assert property (
      @(posedge clk) disable iff (rst)
      !(clic.irq_ack_i && state_q == IDLE)
   ) else $error("clic ack received while idle");
`endif

endmodule

// File: tb/tb_cv32e40x_clic_arbiter.sv
// Bench for cv32e40x_clic_arbiter: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the CLIC source block.
module tb_cv32e40x_clic_arbiter;
   localparam int N = 32;
   localparam int W = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   irq, ie, shv, trig;
   logic [8*N-1:0] lvl;
   logic [N-1:0]   pending;

   int n_checks = 0;
   int n_errors = 0;

   bit [N-1:0] m_pend, m_prev;
   bit         m_valid, m_blank, m_shv;
   bit [W-1:0] m_id;
   bit [7:0]   m_level;

   cv32e40x_clic_arbiter_if #(.CLIC_ID_WIDTH(W)) clic_if ();

   cv32e40x_clic_arbiter #(
      .NUM_IRQ       (N),
      .CLIC_ID_WIDTH (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .irq_i       (irq),
      .irq_ie_i    (ie),
      .irq_level_i (lvl),
      .irq_shv_i   (shv),
      .irq_trig_i  (trig),
      .clic        (clic_if),
      .pending_o   (pending)
   );

   always #5 clk = ~clk;

   function automatic int lv(int i);
      return int'(lvl[8*i +: 8]);
   endfunction

   task automatic model_reset();
      m_pend  = '0;
      m_prev  = '0;
      m_valid = 0;
      m_blank = 0;
      m_shv   = 0;
      m_id    = '0;
      m_level = '0;
   endtask

   task automatic model_load(int best);
      if (best >= 0) begin
         m_valid = 1;
         m_id    = W'(best);
         m_level = 8'(lv(best));
         m_shv   = shv[best];
      end else begin
         m_valid = 0;
      end
   endtask

   // One clock edge of the source block, using pre-edge inputs.
   task automatic model_step();
      int         top;
      int         best;
      bit [N-1:0] np;
      bit         clr;
      top  = 0;
      best = -1;
      for (int i = 0; i < N; i++)
         if (m_pend[i] && ie[i] && lv(i) > top) top = lv(i);
      if (top != 0)
         for (int i = 0; i < N; i++)
            if (m_pend[i] && ie[i] && lv(i) == top) best = i;
      if (m_blank) begin
         m_blank = 0;
         model_load(best);
      end else if (m_valid && clic_if.irq_ack_i) begin
         m_valid = 0;
         m_blank = 1;
      end else begin
         model_load(best);
      end
      for (int i = 0; i < N; i++) begin
         np[i] = irq[i];
         clr   = clic_if.irq_ack_i && int'(clic_if.irq_ack_id_i) == i;
`ifdef CV32E40X_CLIC_ARB_EDGE_EN
         if (trig[i])
            np[i] = (m_pend[i] && !clr) || (irq[i] && !m_prev[i]);
`else
         if (clr && trig[i]) np[i] = irq[i];
`endif
      end
      m_pend = np;
      m_prev = irq;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
   endtask

   task automatic quiesce();
      irq  = '0;
      ie   = '0;
      trig = '0;
      shv  = '0;
      lvl  = '0;
      clic_if.irq_ack_i    = 1'b0;
      clic_if.irq_ack_id_i = '0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      n_checks++;
      if ({clic_if.clic_irq_o, clic_if.clic_irq_id_o,
           clic_if.clic_irq_level_o, clic_if.clic_irq_shv_o} !== 15'd0) begin
         n_errors++;
         $display("FAIL reset_out: got %b%h%h%b want all zero",
                  clic_if.clic_irq_o, clic_if.clic_irq_id_o,
                  clic_if.clic_irq_level_o, clic_if.clic_irq_shv_o);
      end
      n_checks++;
      if (clic_if.clic_irq_priv_o !== 2'b11) begin
         n_errors++;
         $display("FAIL reset_priv: got %b want 11", clic_if.clic_irq_priv_o);
      end
      n_checks++;
      if (pending !== '0) begin
         n_errors++;
         $display("FAIL reset_pend: got %h want 0", pending);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_level_basic();
      ie[3] = 1; lvl[8*3 +: 8] = 8'h40; shv[3] = 1; irq[3] = 1;
      tick();
      n_checks++;
      if (clic_if.clic_irq_o !== 1'b0 || pending[3] !== 1'b1) begin
         n_errors++;
         $display("FAIL level_c1: irq %b pend %b want 0 1",
                  clic_if.clic_irq_o, pending[3]);
      end
      tick();
      n_checks++;
      if ({clic_if.clic_irq_o, clic_if.clic_irq_id_o,
           clic_if.clic_irq_level_o, clic_if.clic_irq_shv_o}
          !== {1'b1, 5'd3, 8'h40, 1'b1}) begin
         n_errors++;
         $display("FAIL level_c2: got %b %0d %h %b want 1 3 40 1",
                  clic_if.clic_irq_o, clic_if.clic_irq_id_o,
                  clic_if.clic_irq_level_o, clic_if.clic_irq_shv_o);
      end
      irq[3] = 0;
      tick();
      n_checks++;
      if (clic_if.clic_irq_o !== 1'b1) begin
         n_errors++;
         $display("FAIL level_drop1: got %b want 1", clic_if.clic_irq_o);
      end
      tick();
      n_checks++;
      if (clic_if.clic_irq_o !== 1'b0 || clic_if.clic_irq_id_o !== 5'd3) begin
         n_errors++;
         $display("FAIL level_drop2: got %b id %0d want 0 id 3",
                  clic_if.clic_irq_o, clic_if.clic_irq_id_o);
      end
      quiesce();
   endtask

   task automatic test_tie();
      lvl[8*5 +: 8] = 8'h80; lvl[8*9 +: 8] = 8'h80; lvl[8*2 +: 8] = 8'h90;
      ie[5] = 1; ie[9] = 1; ie[2] = 0;
      irq[5] = 1; irq[9] = 1; irq[2] = 1;
      repeat (2) tick();
      n_checks++;
      if ({clic_if.clic_irq_o, clic_if.clic_irq_id_o, clic_if.clic_irq_level_o}
          !== {1'b1, 5'd9, 8'h80}) begin
         n_errors++;
         $display("FAIL tie: got %b %0d %h want 1 9 80", clic_if.clic_irq_o,
                  clic_if.clic_irq_id_o, clic_if.clic_irq_level_o);
      end
      ie[2] = 1;
      tick();
      n_checks++;
      if ({clic_if.clic_irq_id_o, clic_if.clic_irq_level_o} !== {5'd2, 8'h90}) begin
         n_errors++;
         $display("FAIL tie_enable: got %0d %h want 2 90",
                  clic_if.clic_irq_id_o, clic_if.clic_irq_level_o);
      end
      quiesce();
   endtask

   task automatic test_preempt();
      lvl[8*4 +: 8] = 8'h10; ie[4] = 1; irq[4] = 1;
      repeat (2) tick();
      lvl[8*6 +: 8] = 8'h30; ie[6] = 1; irq[6] = 1;
      tick();
      n_checks++;
      if (clic_if.clic_irq_o !== 1'b1 || clic_if.clic_irq_id_o !== 5'd4) begin
         n_errors++;
         $display("FAIL preempt_old: got %b %0d want 1 4",
                  clic_if.clic_irq_o, clic_if.clic_irq_id_o);
      end
      tick();
      n_checks++;
      if ({clic_if.clic_irq_o, clic_if.clic_irq_id_o, clic_if.clic_irq_level_o}
          !== {1'b1, 5'd6, 8'h30}) begin
         n_errors++;
         $display("FAIL preempt_new: got %b %0d %h want 1 6 30",
                  clic_if.clic_irq_o, clic_if.clic_irq_id_o,
                  clic_if.clic_irq_level_o);
      end
      irq[4] = 0; irq[6] = 0;
      lvl[8*8 +: 8] = 8'h00; ie[8] = 1; irq[8] = 1;
      repeat (4) tick();
      n_checks++;
      if (clic_if.clic_irq_o !== 1'b0 || pending[8] !== 1'b1) begin
         n_errors++;
         $display("FAIL zero_level: got irq %b pend %b want 0 1",
                  clic_if.clic_irq_o, pending[8]);
      end
      quiesce();
   endtask

   task automatic test_ack_level();
      lvl[8*3 +: 8] = 8'h40; ie[3] = 1; irq[3] = 1;
      repeat (2) tick();
      clic_if.irq_ack_i = 1'b1; clic_if.irq_ack_id_i = 5'd3;
      tick();
      clic_if.irq_ack_i = 1'b0;
      n_checks++;
      if (clic_if.clic_irq_o !== 1'b0 || clic_if.clic_irq_id_o !== 5'd3) begin
         n_errors++;
         $display("FAIL ack_blank: got %b %0d want 0 3",
                  clic_if.clic_irq_o, clic_if.clic_irq_id_o);
      end
      tick();
      n_checks++;
      if (clic_if.clic_irq_o !== 1'b1 || pending[3] !== 1'b1) begin
         n_errors++;
         $display("FAIL ack_level_again: got %b pend %b want 1 1",
                  clic_if.clic_irq_o, pending[3]);
      end
      quiesce();
   endtask

`ifdef CV32E40X_CLIC_ARB_EDGE_EN
   task automatic test_edge();
      lvl[8*7 +: 8] = 8'h20; ie[7] = 1; trig[7] = 1; irq[7] = 1;
      tick();
      irq[7] = 0;
      repeat (2) tick();
      n_checks++;
      if (pending[7] !== 1'b1 || clic_if.clic_irq_o !== 1'b1 ||
          clic_if.clic_irq_id_o !== 5'd7) begin
         n_errors++;
         $display("FAIL edge_hold: pend %b irq %b id %0d want 1 1 7",
                  pending[7], clic_if.clic_irq_o, clic_if.clic_irq_id_o);
      end
      clic_if.irq_ack_i = 1'b1; clic_if.irq_ack_id_i = 5'd7;
      tick();
      clic_if.irq_ack_i = 1'b0;
      n_checks++;
      if (clic_if.clic_irq_o !== 1'b0 || pending[7] !== 1'b0) begin
         n_errors++;
         $display("FAIL edge_clear: irq %b pend %b want 0 0",
                  clic_if.clic_irq_o, pending[7]);
      end
      tick();
      n_checks++;
      if (clic_if.clic_irq_o !== 1'b0) begin
         n_errors++;
         $display("FAIL edge_stay_low: got %b want 0", clic_if.clic_irq_o);
      end
      quiesce();
   endtask

   task automatic test_edge_collision();
      lvl[8*1 +: 8] = 8'h30; ie[1] = 1; trig[1] = 1; irq[1] = 1;
      tick();
      irq[1] = 0;
      repeat (2) tick();
      clic_if.irq_ack_i = 1'b1; clic_if.irq_ack_id_i = 5'd1; irq[1] = 1;
      tick();
      clic_if.irq_ack_i = 1'b0; irq[1] = 0;
      n_checks++;
      if (pending[1] !== 1'b1 || clic_if.clic_irq_o !== 1'b0) begin
         n_errors++;
         $display("FAIL collide_n1: pend %b irq %b want 1 0",
                  pending[1], clic_if.clic_irq_o);
      end
      tick();
      n_checks++;
      if (clic_if.clic_irq_o !== 1'b1 || clic_if.clic_irq_id_o !== 5'd1) begin
         n_errors++;
         $display("FAIL collide_n2: got %b %0d want 1 1",
                  clic_if.clic_irq_o, clic_if.clic_irq_id_o);
      end
      quiesce();
   endtask
`else
   task automatic test_trig_ignored();
      trig = '1;
      lvl[8*7 +: 8] = 8'h20; ie[7] = 1; irq[7] = 1;
      tick();
      irq[7] = 0;
      tick();
      n_checks++;
      if (pending[7] !== 1'b0 || clic_if.clic_irq_o !== 1'b1) begin
         n_errors++;
         $display("FAIL trig_level_c2: pend %b irq %b want 0 1",
                  pending[7], clic_if.clic_irq_o);
      end
      tick();
      n_checks++;
      if (clic_if.clic_irq_o !== 1'b0) begin
         n_errors++;
         $display("FAIL trig_level_c3: got %b want 0", clic_if.clic_irq_o);
      end
      quiesce();
   endtask
`endif

   task automatic test_reset_blank();
      lvl[8*3 +: 8] = 8'h40; ie[3] = 1; irq[3] = 1;
      repeat (2) tick();
      clic_if.irq_ack_i = 1'b1; clic_if.irq_ack_id_i = 5'd3;
      tick();
      clic_if.irq_ack_i = 1'b0;
      rst = 1'b1;
      #2;
      model_reset();
      n_checks++;
      if ({clic_if.clic_irq_o, clic_if.clic_irq_id_o, clic_if.clic_irq_level_o,
           clic_if.clic_irq_shv_o, pending} !== 47'd0) begin
         n_errors++;
         $display("FAIL rst_blank: irq %b id %0d lvl %h shv %b pend %h want 0",
                  clic_if.clic_irq_o, clic_if.clic_irq_id_o,
                  clic_if.clic_irq_level_o, clic_if.clic_irq_shv_o, pending);
      end
      tick();
      rst = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (clic_if.clic_irq_o !== 1'b1 || clic_if.clic_irq_id_o !== 5'd3) begin
         n_errors++;
         $display("FAIL rst_recover: got %b %0d want 1 3",
                  clic_if.clic_irq_o, clic_if.clic_irq_id_o);
      end
      quiesce();
   endtask

   task automatic test_random();
      bit [7:0]   pick [5];
      logic [48:0] got, exp;
      pick = '{8'h00, 8'h10, 8'h20, 8'h80, 8'hff};
      for (int i = 0; i < N; i++)
         lvl[8*i +: 8] = pick[$urandom_range(0, 4)];
      trig = $urandom;
      shv  = $urandom;
      ie   = $urandom;
      for (int c = 0; c < 400; c++) begin
         irq = $urandom & $urandom & $urandom;
         if (c % 16 == 0) ie = $urandom;
         if ((m_valid || m_blank) && $urandom_range(0, 2) == 0) begin
            clic_if.irq_ack_i    = 1'b1;
            clic_if.irq_ack_id_i = $urandom_range(0, 1) ? m_id : W'($urandom);
         end else begin
            clic_if.irq_ack_i = 1'b0;
         end
         tick();
         got = {clic_if.clic_irq_o, clic_if.clic_irq_id_o,
                clic_if.clic_irq_level_o, clic_if.clic_irq_shv_o,
                clic_if.clic_irq_priv_o, pending};
         exp = {m_valid, m_id, m_level, m_shv, 2'b11, m_pend};
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL random_c%0d: got %h want %h", c, got, exp);
         end
      end
      quiesce();
   endtask

   initial begin
      irq  = '0;
      ie   = '0;
      shv  = '0;
      trig = '0;
      lvl  = '0;
      clic_if.irq_ack_i    = 1'b0;
      clic_if.irq_ack_id_i = '0;
      model_reset();
      test_reset();
      test_level_basic();
      test_tie();
      test_preempt();
      test_ack_level();
`ifdef CV32E40X_CLIC_ARB_EDGE_EN
      test_edge();
      test_edge_collision();
`else
      test_trig_ignored();
`endif
      test_reset_blank();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
